sa_ctrl: RTL and testbench
==========================

SA_CTRL -- requirements
Module: sa_ctrl

Interface
REQ-001 SHALL have parameter ARRAY_WIDTH, default 8, PE columns.
REQ-002 SHALL have parameter ARRAY_HEIGHT, default 8, PE rows.
REQ-003 SHALL have parameters X_W=8 and W_W=8, activation and weight widths.
REQ-004 SHALL have parameter RBUF_DEPTH, default 8, read-buffer entries per row.
REQ-005 SHALL have parameter TIMEOUT_CYC, default 1024, WAIT watchdog limit.
REQ-006 SHALL have port clk_i, input, 1: the single clock; all logic on its rising edge.
REQ-007 SHALL have port rst_ni, input, 1: asynchronous active-low reset.
REQ-008 SHALL have ports cmd_v_i (in, 1), cmd_ready_o (out, 1), cmd_skip_w_i (in, 1): job handshake; skip reuses the loaded weights.
REQ-009 SHALL have ports w_data_i (in, W_W), w_v_i (in, 1), w_ready_o (out, 1): weight stream.
REQ-010 SHALL have ports x_data_i (in, X_W), x_v_i (in, 1), x_ready_o (out, 1): activation stream.
REQ-011 SHALL have ports arr_w_o (out, W_W), arr_w_addr_o (out, clog2(ARRAY_WIDTH*ARRAY_HEIGHT)), arr_w_en_o (out, 1): array weight write.
REQ-012 SHALL have ports arr_rbuf_waddr_o (out, clog2(ARRAY_HEIGHT)+clog2(RBUF_DEPTH)), arr_rbuf_wdata_o (out, X_W), arr_rbuf_w_vo (out, 1): read-buffer write, row index in upper bits, entry in lower bits.
REQ-013 SHALL have ports arr_start_vo (out, 1) and arr_mac_v_i (in, ARRAY_WIDTH): start pulse and per-column result valid.
REQ-014 SHALL have ports busy_o (out, 1), done_o (out, 1), err_o (out, 1).

Function
REQ-015 SHALL implement FSM states IDLE, LOAD_W, LOAD_X, START, WAIT, DONE.
REQ-016 SHALL assert cmd_ready_o only in IDLE; a cmd_v_i & cmd_ready_o beat moves to LOAD_X if cmd_skip_w_i=1, otherwise to LOAD_W.
REQ-017 SHALL, in LOAD_W, drive w_ready_o=1, arr_w_en_o=w_v_i, arr_w_o=w_data_i combinationally, and arr_w_addr_o=beat counter (0..ARRAY_WIDTH*ARRAY_HEIGHT-1), incrementing the counter on each accepted beat.
REQ-018 SHALL leave LOAD_W for LOAD_X on acceptance of beat ARRAY_WIDTH*ARRAY_HEIGHT-1, clearing the counter.
REQ-019 SHALL, in LOAD_X, drive x_ready_o=1, arr_rbuf_w_vo=x_v_i, arr_rbuf_wdata_o=x_data_i, and arr_rbuf_waddr_o=beat counter (0..ARRAY_HEIGHT*RBUF_DEPTH-1); on the final beat it moves to START.
REQ-020 SHALL assert arr_start_vo for exactly one cycle in START, then move to WAIT.
REQ-021 SHALL, in WAIT, count cycles with arr_mac_v_i[ARRAY_WIDTH-1]=1 and move to DONE when the count reaches RBUF_DEPTH.
REQ-022 SHALL pulse done_o for one cycle in DONE and return to IDLE on the next cycle.
REQ-023 SHALL hold busy_o=1 in every state except IDLE.
REQ-024 SHALL drive w_ready_o, x_ready_o, arr_w_en_o, arr_rbuf_w_vo, and arr_start_vo to 0 outside their respective states; stream input is ignored without ready.
REQ-025 SHALL ignore arr_mac_v_i outside WAIT.

Reset
REQ-026 SHALL, on rst_ni=0, immediately enter IDLE, zero all counters, and drive every output to 0 except cmd_ready_o, which becomes 1 after release.
REQ-027 SHALL abandon a job interrupted by reset mid-operation; no done_o or err_o is issued for it.

Configuration
REQ-028 With SA_CTRL_TIMEOUT_EN defined, SHALL count WAIT cycles; at TIMEOUT_CYC it pulses err_o for one cycle and returns to IDLE with no done_o.
REQ-029 Without SA_CTRL_TIMEOUT_EN, SHALL tie err_o to 0 and wait indefinitely in WAIT.

Structure
REQ-030 SHALL take its state enum type and default parameter constants from the shared package sa_pkg.
REQ-031 SHALL instantiate a single sub-module, sa_beat_cnt, as the load/result beat counter, with clear, enable, and terminal-count output.

Verification
REQ-032 Full job, 8x8 array, depth 8: 64 weight beats and 64 x beats, then 8 last-column valids -> weight addresses 0..63 in order, rbuf addresses 0..63, one start pulse, done_o after the 8th valid.
REQ-033 Skip-weights command -> no arr_w_en_o, LOAD_X entered the cycle after the handshake, and done_o still issued.
REQ-034 Stalled streams (w_v_i/x_v_i toggled every other cycle) -> addresses advance only on accepted beats, with no gaps or repeats.
REQ-035 rst_ni asserted in LOAD_X at beat 20 -> all outputs 0 asynchronously, cmd_ready_o=1 after release, and the next job restarts at address 0.
REQ-036 With SA_CTRL_TIMEOUT_EN and TIMEOUT_CYC=16, no mac valids -> err_o pulses at WAIT cycle 16, no done_o, and the controller returns to IDLE.

Source files
------------

// File: rtl/sa_pkg.sv
// -----------------------------------------------------------------------------
// sa_pkg
// Shared types and default constants for the systolic-array controller.
//   sa_state_e      : controller FSM state encoding
//   SA_*            : default parameter values picked up by sa_ctrl
//   sa_max          : larger of two integers
//   sa_clog2_min1   : ceil(log2(n)), never less than 1 (safe vector width)
// -----------------------------------------------------------------------------
package sa_pkg;

    localparam int SA_ARRAY_WIDTH  = 8;
    localparam int SA_ARRAY_HEIGHT = 8;
    localparam int SA_X_W          = 8;
    localparam int SA_W_W          = 8;
    localparam int SA_RBUF_DEPTH   = 8;
    localparam int SA_TIMEOUT_CYC  = 1024;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_LOAD_W = 3'd1,
        ST_LOAD_X = 3'd2,
        ST_START  = 3'd3,
        ST_WAIT   = 3'd4,
        ST_DONE   = 3'd5
    } sa_state_e;

    function automatic int sa_max(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

    function automatic int sa_clog2_min1(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/sa_beat_cnt.sv
// -----------------------------------------------------------------------------
// sa_beat_cnt
// Shared beat counter for the weight load, activation load and result phases.
// Counts up from zero so the count doubles as the write address; the
// terminal-count flag compares against a value supplied per phase.
// Ports:
//   clk_i, rst_ni : clock, asynchronous active-low reset
//   clr_i         : synchronous clear (wins over en_i)
//   en_i          : advance by one
//   tc_val_i      : terminal count for the current phase
//   cnt_o         : current count
//   tc_o          : cnt_o equals tc_val_i
// -----------------------------------------------------------------------------
module sa_beat_cnt #(
    parameter int CNT_W = 6
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             clr_i,
    input  logic             en_i,
    input  logic [CNT_W-1:0] tc_val_i,
    output logic [CNT_W-1:0] cnt_o,
    output logic             tc_o
);

    logic [CNT_W-1:0] r_cnt;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_cnt <= '0;
        end else if (clr_i) begin
            r_cnt <= '0;
        end else if (en_i) begin
            r_cnt <= r_cnt + CNT_W'(1);
        end
    end

    assign cnt_o = r_cnt;
    assign tc_o  = (r_cnt == tc_val_i);

endmodule

// File: rtl/sa_ctrl.sv
// -----------------------------------------------------------------------------
// sa_ctrl
// Job sequencer for a systolic array: loads weights (unless skipped), fills
// the per-row read buffers with activations, fires the array, then waits for
// RBUF_DEPTH result beats on the last column.
//
// Build option: define SA_CTRL_TIMEOUT_EN to enable the WAIT watchdog. After
// TIMEOUT_CYC cycles in WAIT without completion, err_o pulses on the last
// WAIT cycle and the job is dropped (no done_o). Without it err_o is 0 and
// WAIT has no time limit.
//
// Ports:
//   clk_i, rst_ni                    : clock, asynchronous active-low reset
//   cmd_v_i/cmd_ready_o/cmd_skip_w_i : job handshake, skip keeps loaded weights
//   w_data_i/w_v_i/w_ready_o         : weight stream
//   x_data_i/x_v_i/x_ready_o         : activation stream
//   arr_w_o/arr_w_addr_o/arr_w_en_o  : array weight write port
//   arr_rbuf_waddr_o/_wdata_o/_w_vo  : read-buffer write, {row, entry}
//   arr_start_vo                     : one-cycle array start
//   arr_mac_v_i                      : per-column result valid
//   busy_o, done_o, err_o            : status
//
// state   | meaning
// --------+-----------------------------------------------------------
// IDLE    | ready for a command
// LOAD_W  | streaming ARRAY_WIDTH*ARRAY_HEIGHT weights into the array
// LOAD_X  | streaming ARRAY_HEIGHT*RBUF_DEPTH activations into rbufs
// START   | one-cycle start pulse to the array
// WAIT    | counting last-column result valids up to RBUF_DEPTH
// DONE    | one-cycle completion pulse
// -----------------------------------------------------------------------------
module sa_ctrl
    import sa_pkg::*;
#(
    parameter int ARRAY_WIDTH  = SA_ARRAY_WIDTH,
    parameter int ARRAY_HEIGHT = SA_ARRAY_HEIGHT,
    parameter int X_W          = SA_X_W,
    parameter int W_W          = SA_W_W,
    parameter int RBUF_DEPTH   = SA_RBUF_DEPTH,
    parameter int TIMEOUT_CYC  = SA_TIMEOUT_CYC
) (
    input  logic                                                clk_i,
    input  logic                                                rst_ni,
    input  logic                                                cmd_v_i,
    output logic                                                cmd_ready_o,
    input  logic                                                cmd_skip_w_i,
    input  logic [W_W-1:0]                                      w_data_i,
    input  logic                                                w_v_i,
    output logic                                                w_ready_o,
    input  logic [X_W-1:0]                                      x_data_i,
    input  logic                                                x_v_i,
    output logic                                                x_ready_o,
    output logic [W_W-1:0]                                      arr_w_o,
    output logic [$clog2(ARRAY_WIDTH*ARRAY_HEIGHT)-1:0]         arr_w_addr_o,
    output logic                                                arr_w_en_o,
    output logic [$clog2(ARRAY_HEIGHT)+$clog2(RBUF_DEPTH)-1:0]  arr_rbuf_waddr_o,
    output logic [X_W-1:0]                                      arr_rbuf_wdata_o,
    output logic                                                arr_rbuf_w_vo,
    output logic                                                arr_start_vo,
    input  logic [ARRAY_WIDTH-1:0]                              arr_mac_v_i,
    output logic                                                busy_o,
    output logic                                                done_o,
    output logic                                                err_o
);

    localparam int LP_NW    = ARRAY_WIDTH * ARRAY_HEIGHT;
    localparam int LP_NX    = ARRAY_HEIGHT * RBUF_DEPTH;
    localparam int LP_WA_W  = $clog2(LP_NW);
    localparam int LP_ROW_W = $clog2(ARRAY_HEIGHT);
    localparam int LP_ENT_W = $clog2(RBUF_DEPTH);
    localparam int LP_CNT_W = sa_clog2_min1(sa_max(LP_NW, LP_NX));

    sa_state_e             r_state;
    sa_state_e             w_state_nxt;
    logic [LP_CNT_W-1:0]   w_cnt;
    logic [LP_CNT_W-1:0]   w_tc_val;
    logic                  w_cnt_tc;
    logic                  w_cnt_en;
    logic                  w_cnt_clr;
    logic                  w_res_beat;
    logic                  w_res_last;
    logic                  w_timeout;
    logic                  w_unused_mac;

    // Only the last column marks a completed output row.
    assign w_res_beat   = (r_state == ST_WAIT) && arr_mac_v_i[ARRAY_WIDTH-1];
    assign w_res_last   = w_res_beat && w_cnt_tc;
    assign w_unused_mac = ^arr_mac_v_i;

    // -------------------------------------------------------------------------
    // State register
    // -------------------------------------------------------------------------
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Terminal count per phase; kept apart from next-state so the tc flag
    // does not loop back into the process that produces its compare value.
    always_comb begin
        w_tc_val = '0;
        case (r_state)
            ST_LOAD_W: w_tc_val = LP_CNT_W'(LP_NW - 1);
            ST_LOAD_X: w_tc_val = LP_CNT_W'(LP_NX - 1);
            ST_WAIT:   w_tc_val = LP_CNT_W'(RBUF_DEPTH - 1);
            default:   w_tc_val = '0;
        endcase
    end

    // -------------------------------------------------------------------------
    // Next state and counter enable
    // -------------------------------------------------------------------------
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_en    = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (cmd_v_i) begin
                    w_state_nxt = cmd_skip_w_i ? ST_LOAD_X : ST_LOAD_W;
                end
            end
            ST_LOAD_W: begin
                w_cnt_en = w_v_i;
                if (w_v_i && w_cnt_tc) begin
                    w_state_nxt = ST_LOAD_X;
                end
            end
            ST_LOAD_X: begin
                w_cnt_en = x_v_i;
                if (x_v_i && w_cnt_tc) begin
                    w_state_nxt = ST_START;
                end
            end
            ST_START: begin
                w_state_nxt = ST_WAIT;
            end
            ST_WAIT: begin
                w_cnt_en = w_res_beat;
                // A completing beat wins over a watchdog expiring the same cycle.
                if (w_res_last) begin
                    w_state_nxt = ST_DONE;
                end else if (w_timeout) begin
                    w_state_nxt = ST_IDLE;
                end
            end
            ST_DONE: begin
                w_state_nxt = ST_IDLE;
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // Every phase starts its count from zero.
    assign w_cnt_clr = (r_state != w_state_nxt) || (r_state == ST_IDLE);

    sa_beat_cnt #(
        .CNT_W (LP_CNT_W)
    ) u_beat_cnt (
        .clk_i    (clk_i),
        .rst_ni   (rst_ni),
        .clr_i    (w_cnt_clr),
        .en_i     (w_cnt_en),
        .tc_val_i (w_tc_val),
        .cnt_o    (w_cnt),
        .tc_o     (w_cnt_tc)
    );

    // -------------------------------------------------------------------------
    // Watchdog
    // -------------------------------------------------------------------------
`ifdef SA_CTRL_TIMEOUT_EN
    localparam int LP_WD_W = sa_clog2_min1(TIMEOUT_CYC + 1);

    logic [LP_WD_W-1:0] r_wd_cnt;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_wd_cnt <= '0;
        end else if (r_state == ST_WAIT) begin
            r_wd_cnt <= r_wd_cnt + LP_WD_W'(1);
        end else begin
            r_wd_cnt <= '0;
        end
    end

    assign w_timeout = (r_state == ST_WAIT) && (r_wd_cnt == LP_WD_W'(TIMEOUT_CYC - 1));
    assign err_o     = w_timeout && !w_res_last;
`else
    logic [31:0] w_unused_timeout;

    assign w_unused_timeout = TIMEOUT_CYC;
    assign w_timeout        = 1'b0;
    assign err_o            = 1'b0;
`endif

    // -------------------------------------------------------------------------
    // Outputs
    // -------------------------------------------------------------------------
    // Held low while reset is asserted even though the state is already IDLE.
    assign cmd_ready_o = (r_state == ST_IDLE) && rst_ni;
    assign busy_o      = (r_state != ST_IDLE);
    assign done_o      = (r_state == ST_DONE);

    always_comb begin
        w_ready_o        = 1'b0;
        x_ready_o        = 1'b0;
        arr_w_o          = '0;
        arr_w_addr_o     = '0;
        arr_w_en_o       = 1'b0;
        arr_rbuf_waddr_o = '0;
        arr_rbuf_wdata_o = '0;
        arr_rbuf_w_vo    = 1'b0;
        arr_start_vo     = 1'b0;
        case (r_state)
            ST_LOAD_W: begin
                w_ready_o    = 1'b1;
                arr_w_en_o   = w_v_i;
                arr_w_o      = w_data_i;
                arr_w_addr_o = LP_WA_W'(w_cnt);
            end
            ST_LOAD_X: begin
                x_ready_o        = 1'b1;
                arr_rbuf_w_vo    = x_v_i;
                arr_rbuf_wdata_o = x_data_i;
                // Linear beat index split into {row, entry}.
                arr_rbuf_waddr_o = {LP_ROW_W'(32'(w_cnt) / RBUF_DEPTH),
                                    LP_ENT_W'(32'(w_cnt) % RBUF_DEPTH)};
            end
            ST_START: begin
                arr_start_vo = 1'b1;
            end
            default: begin
            end
        endcase
    end

endmodule

// File: tb/tb_sa_ctrl.sv
module tb_sa_ctrl;

    localparam int AW = 8;
    localparam int AH = 8;
    localparam int XW = 8;
    localparam int WW = 8;
    localparam int RD = 8;
    localparam int TO = 16;
    localparam int NW = AW * AH;
    localparam int NX = AH * RD;
    localparam int ENT_W = $clog2(RD);

    logic           clk_i = 1'b0;
    logic           rst_ni = 1'b0;
    logic           cmd_v_i = 1'b0;
    logic           cmd_ready_o;
    logic           cmd_skip_w_i = 1'b0;
    logic [WW-1:0]  w_data_i = '0;
    logic           w_v_i = 1'b0;
    logic           w_ready_o;
    logic [XW-1:0]  x_data_i = '0;
    logic           x_v_i = 1'b0;
    logic           x_ready_o;
    logic [WW-1:0]  arr_w_o;
    logic [5:0]     arr_w_addr_o;
    logic           arr_w_en_o;
    logic [5:0]     arr_rbuf_waddr_o;
    logic [XW-1:0]  arr_rbuf_wdata_o;
    logic           arr_rbuf_w_vo;
    logic           arr_start_vo;
    logic [AW-1:0]  arr_mac_v_i = '0;
    logic           busy_o;
    logic           done_o;
    logic           err_o;

    int n_tests = 0;
    int n_fail  = 0;

    sa_ctrl #(
        .ARRAY_WIDTH  (AW),
        .ARRAY_HEIGHT (AH),
        .X_W          (XW),
        .W_W          (WW),
        .RBUF_DEPTH   (RD),
        .TIMEOUT_CYC  (TO)
    ) dut (
        .clk_i            (clk_i),
        .rst_ni           (rst_ni),
        .cmd_v_i          (cmd_v_i),
        .cmd_ready_o      (cmd_ready_o),
        .cmd_skip_w_i     (cmd_skip_w_i),
        .w_data_i         (w_data_i),
        .w_v_i            (w_v_i),
        .w_ready_o        (w_ready_o),
        .x_data_i         (x_data_i),
        .x_v_i            (x_v_i),
        .x_ready_o        (x_ready_o),
        .arr_w_o          (arr_w_o),
        .arr_w_addr_o     (arr_w_addr_o),
        .arr_w_en_o       (arr_w_en_o),
        .arr_rbuf_waddr_o (arr_rbuf_waddr_o),
        .arr_rbuf_wdata_o (arr_rbuf_wdata_o),
        .arr_rbuf_w_vo    (arr_rbuf_w_vo),
        .arr_start_vo     (arr_start_vo),
        .arr_mac_v_i      (arr_mac_v_i),
        .busy_o           (busy_o),
        .done_o           (done_o),
        .err_o            (err_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_all_zero(input string tag);
        chk(tag, 64'({arr_w_o, arr_w_addr_o, arr_w_en_o, arr_rbuf_waddr_o, arr_rbuf_wdata_o,
                      arr_rbuf_w_vo, arr_start_vo, busy_o, done_o, err_o,
                      w_ready_o, x_ready_o, cmd_ready_o}), 64'd0);
    endtask

    // Expected read-buffer address of linear activation beat n: {row, entry}.
    function automatic logic [5:0] rbuf_addr(input int n);
        return 6'(((n / RD) << ENT_W) | (n % RD));
    endfunction

    // One job. Drives at negedge, samples 1 time unit later.
    //   skip     : reuse weights
    //   stall    : valids toggle every other cycle instead of random
    //   abort    : assert reset at activation beat 20 and return
    //   hold     : cycles of no result valid before results start
    //   expect_to: no result valids at all, expect the watchdog
    task automatic run_job(input bit skip, input bit stall, input bit abort,
                           input int hold, input bit expect_to);
        int acc;
        int cyc;
        int cnt;
        @(negedge clk_i);
        cmd_v_i = 1'b1;
        cmd_skip_w_i = skip;
        #1;
        chk("cmd_ready_idle", cmd_ready_o, 1);
        chk("busy_idle", busy_o, 0);
        @(negedge clk_i);
        cmd_v_i = 1'b0;
        cmd_skip_w_i = 1'($urandom);

        if (!skip) begin
            acc = 0;
            cyc = 0;
            while (acc < NW && cyc < NW * 4) begin
                w_v_i = stall ? (cyc % 2 == 0) : ($urandom_range(0, 3) != 0);
                w_data_i = WW'($urandom);
                x_v_i = 1'($urandom);
                x_data_i = XW'($urandom);
                arr_mac_v_i = AW'($urandom);
                #1;
                chk("w_ready", w_ready_o, 1);
                chk("w_x_ready_low", x_ready_o, 0);
                chk("w_rbuf_v_low", arr_rbuf_w_vo, 0);
                chk("w_busy", busy_o, 1);
                chk("w_en", arr_w_en_o, w_v_i);
                if (w_v_i) begin
                    chk("w_addr", arr_w_addr_o, acc);
                    chk("w_data", arr_w_o, w_data_i);
                    acc++;
                end
                cyc++;
                @(negedge clk_i);
            end
            chk("w_beats", acc, NW);
            w_v_i = 1'b0;
        end

        acc = 0;
        cyc = 0;
        while (acc < NX && cyc < NX * 4) begin
            x_v_i = stall ? (cyc % 2 == 0) : ($urandom_range(0, 3) != 0);
            x_data_i = XW'($urandom);
            w_v_i = 1'($urandom);
            w_data_i = WW'($urandom);
            arr_mac_v_i = AW'($urandom);
            if (abort && acc == 20) begin
                x_v_i = 1'b1;
                #1;
                chk("abort_addr", arr_rbuf_waddr_o, rbuf_addr(20));
                rst_ni = 1'b0;
                #1;
                chk_all_zero("abort_async_zero");
                @(negedge clk_i);
                cmd_v_i = 1'b1;
                #1;
                chk_all_zero("abort_held_zero");
                cmd_v_i = 1'b0;
                x_v_i = 1'b0;
                w_v_i = 1'b0;
                arr_mac_v_i = '0;
                rst_ni = 1'b1;
                #1;
                chk("abort_ready", cmd_ready_o, 1);
                chk("abort_busy", busy_o, 0);
                return;
            end
            #1;
            chk("x_ready", x_ready_o, 1);
            chk("x_w_ready_low", w_ready_o, 0);
            chk("x_w_en_low", arr_w_en_o, 0);
            chk("x_busy", busy_o, 1);
            chk("x_rbuf_v", arr_rbuf_w_vo, x_v_i);
            if (x_v_i) begin
                chk("x_addr", arr_rbuf_waddr_o, rbuf_addr(acc));
                chk("x_data", arr_rbuf_wdata_o, x_data_i);
                acc++;
            end
            cyc++;
            @(negedge clk_i);
        end
        chk("x_beats", acc, NX);
        x_v_i = 1'b0;
        w_v_i = 1'b0;

        arr_mac_v_i = AW'($urandom);
        #1;
        chk("start_pulse", arr_start_vo, 1);
        chk("start_x_ready_low", x_ready_o, 0);
        chk("start_busy", busy_o, 1);
        @(negedge clk_i);

        if (expect_to) begin
            for (int i = 0; i < TO; i++) begin
                arr_mac_v_i = '0;
                #1;
                chk("to_err", err_o, (i == TO - 1));
                chk("to_no_done", done_o, 0);
                chk("to_busy", busy_o, 1);
                @(negedge clk_i);
            end
            #1;
            chk("to_idle_ready", cmd_ready_o, 1);
            chk("to_idle_busy", busy_o, 0);
            chk("to_err_clear", err_o, 0);
            chk("to_no_done_after", done_o, 0);
            return;
        end

        cnt = 0;
        cyc = 0;
        while (cnt < RD && cyc < hold + 200) begin
            if (cyc < hold) begin
                arr_mac_v_i = '0;
            end else begin
                arr_mac_v_i = AW'($urandom);
                // Stay inside any watchdog window the build may have.
                if ((RD - cnt) >= (TO - cyc)) arr_mac_v_i[AW-1] = 1'b1;
            end
            #1;
            chk("wait_start_low", arr_start_vo, 0);
            chk("wait_no_done", done_o, 0);
            chk("wait_no_err", err_o, 0);
            chk("wait_busy", busy_o, 1);
            chk("wait_ready_low", cmd_ready_o, 0);
            if (arr_mac_v_i[AW-1]) cnt++;
            cyc++;
            @(negedge clk_i);
        end
        chk("mac_count", cnt, RD);
        arr_mac_v_i = AW'($urandom);
        #1;
        chk("done_pulse", done_o, 1);
        chk("done_busy", busy_o, 1);
        chk("done_ready_low", cmd_ready_o, 0);
        @(negedge clk_i);
        arr_mac_v_i = AW'($urandom);
        #1;
        chk("after_done_low", done_o, 0);
        chk("after_done_busy", busy_o, 0);
        chk("after_done_ready", cmd_ready_o, 1);
        arr_mac_v_i = '0;
    endtask

    initial begin
        repeat (2) @(posedge clk_i);
        #1;
        chk_all_zero("reset_zero");
        @(negedge clk_i);
        rst_ni = 1'b1;
        #1;
        chk("release_ready", cmd_ready_o, 1);
        chk("release_busy", busy_o, 0);

        run_job(1'b0, 1'b0, 1'b0, 0, 1'b0);   // full job, random gaps
        run_job(1'b1, 1'b0, 1'b0, 0, 1'b0);   // skip weights
        run_job(1'b0, 1'b1, 1'b0, 0, 1'b0);   // every-other-cycle stalls
        run_job(1'b0, 1'b0, 1'b1, 0, 1'b0);   // reset at activation beat 20
        run_job(1'b0, 1'b0, 1'b0, 0, 1'b0);   // restarts from address 0
`ifdef SA_CTRL_TIMEOUT_EN
        run_job(1'b1, 1'b0, 1'b0, 0, 1'b1);   // watchdog expiry
        run_job(1'b1, 1'b0, 1'b0, 0, 1'b0);   // recovers afterwards
`else
        run_job(1'b1, 1'b0, 1'b0, 40, 1'b0);  // long wait, no time limit
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
